// File: rtl/decode_stage_p.sv
// RV32 decode stage: combinational decode of the fetched word into a
// two-entry (main + skid) output buffer, with latched error reporting.
// exec_kind encoding:
//   0 NOP   1 LUI   2 AUIPC  3 JAL   4 JALR
//   5 BEQ   6 BNE   7 BLT    8 BGE   9 BLTU  10 BGEU
//  11 LB   12 LH   13 LW    14 LBU  15 LHU
//  16 SB   17 SH   18 SW
//  19 ADDI 20 SLTI 21 SLTIU 22 XORI 23 ORI   24 ANDI 25 SLLI 26 SRLI 27 SRAI
//  28 ADD  29 SUB  30 SLL   31 SLT  32 SLTU  33 XOR  34 SRL  35 SRA  36 OR  37 AND
module decode_stage_p #(
   parameter int NUM_REGS      = 16,
   parameter bit SYSTEM_AS_NOP = 1'b1
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        fetch_valid,
   output logic                        fetch_ready,
   input  logic [31:0]                 fetch_instr,
   input  logic [31:0]                 fetch_pc,
   output logic                        exec_valid,
   input  logic                        exec_ready,
   output logic [5:0]                  exec_kind,
   output logic [31:0]                 exec_imm,
   output logic [$clog2(NUM_REGS)-1:0] exec_rd,
   output logic [$clog2(NUM_REGS)-1:0] exec_rs1,
   output logic [$clog2(NUM_REGS)-1:0] exec_rs2,
   output logic [31:0]                 exec_pc,
   input  logic                        flush,
   input  logic                        error_clear,
   output logic                        error_valid,
   output logic [1:0]                  error_cause,
   output logic [31:0]                 error_pc,
   output logic [31:0]                 error_instr
);
   localparam int REG_BITS = $clog2(NUM_REGS);

   typedef struct packed {
      logic [5:0]          kind;
      logic [31:0]         imm;
      logic [REG_BITS-1:0] rd;
      logic [REG_BITS-1:0] rs1;
      logic [REG_BITS-1:0] rs2;
      logic [31:0]         pc;
   } op_t;

   // Only the 16-register configuration can see an out-of-range index.
   function automatic logic reg_oob(input logic [4:0] idx);
      return (NUM_REGS < 32) && idx[4];
   endfunction

   logic [6:0] opc, f7;
   logic [2:0] f3;
   logic [4:0] rd5, rs15, rs25;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
   logic [5:0] dec_kind;
   logic [31:0] dec_imm;
   logic use_rd, use_rs1, use_rs2, bad_opc, bad_fn, bad_reg;
   logic [1:0] dec_cause;
   op_t dec_op;

   assign opc    = fetch_instr[6:0];
   assign f3     = fetch_instr[14:12];
   assign f7     = fetch_instr[31:25];
   assign rd5    = fetch_instr[11:7];
   assign rs15   = fetch_instr[19:15];
   assign rs25   = fetch_instr[24:20];
   assign imm_i  = {{20{fetch_instr[31]}}, fetch_instr[31:20]};
   assign imm_s  = {{20{fetch_instr[31]}}, fetch_instr[31:25], fetch_instr[11:7]};
   assign imm_b  = {{19{fetch_instr[31]}}, fetch_instr[31], fetch_instr[7],
                    fetch_instr[30:25], fetch_instr[11:8], 1'b0};
   assign imm_u  = {fetch_instr[31:12], 12'h000};
   assign imm_j  = {{11{fetch_instr[31]}}, fetch_instr[31], fetch_instr[19:12],
                    fetch_instr[20], fetch_instr[30:21], 1'b0};
   assign imm_sh = {27'd0, fetch_instr[24:20]};

   // Decode opcode/funct fields into kind, immediate and used-register flags.
   always_comb begin
      dec_kind = 6'd0;
      dec_imm  = 32'd0;
      use_rd   = 1'b0;
      use_rs1  = 1'b0;
      use_rs2  = 1'b0;
      bad_opc  = 1'b0;
      bad_fn   = 1'b0;
      case (opc)
         7'h37: begin dec_kind = 6'd1; dec_imm = imm_u; use_rd = 1'b1; end
         7'h17: begin dec_kind = 6'd2; dec_imm = imm_u; use_rd = 1'b1; end
         7'h6F: begin dec_kind = 6'd3; dec_imm = imm_j; use_rd = 1'b1; end
         7'h67: begin
            dec_kind = 6'd4; dec_imm = imm_i; use_rd = 1'b1; use_rs1 = 1'b1;
            bad_fn = (f3 != 3'd0);
         end
         7'h63: begin
            dec_imm = imm_b; use_rs1 = 1'b1; use_rs2 = 1'b1;
            case (f3)
               3'd0: dec_kind = 6'd5;
               3'd1: dec_kind = 6'd6;
               3'd4: dec_kind = 6'd7;
               3'd5: dec_kind = 6'd8;
               3'd6: dec_kind = 6'd9;
               3'd7: dec_kind = 6'd10;
               default: bad_fn = 1'b1;
            endcase
         end
         7'h03: begin
            dec_imm = imm_i; use_rd = 1'b1; use_rs1 = 1'b1;
            case (f3)
               3'd0: dec_kind = 6'd11;
               3'd1: dec_kind = 6'd12;
               3'd2: dec_kind = 6'd13;
               3'd4: dec_kind = 6'd14;
               3'd5: dec_kind = 6'd15;
               default: bad_fn = 1'b1;
            endcase
         end
         7'h23: begin
            dec_imm = imm_s; use_rs1 = 1'b1; use_rs2 = 1'b1;
            case (f3)
               3'd0: dec_kind = 6'd16;
               3'd1: dec_kind = 6'd17;
               3'd2: dec_kind = 6'd18;
               default: bad_fn = 1'b1;
            endcase
         end
         7'h13: begin
            dec_imm = imm_i; use_rd = 1'b1; use_rs1 = 1'b1;
            case (f3)
               3'd0: dec_kind = 6'd19;
               3'd2: dec_kind = 6'd20;
               3'd3: dec_kind = 6'd21;
               3'd4: dec_kind = 6'd22;
               3'd6: dec_kind = 6'd23;
               3'd7: dec_kind = 6'd24;
               3'd1: begin
                  dec_kind = 6'd25; dec_imm = imm_sh; bad_fn = (f7 != 7'h00);
               end
               default: begin
                  dec_imm = imm_sh;
                  if (f7 == 7'h00)      dec_kind = 6'd26;
                  else if (f7 == 7'h20) dec_kind = 6'd27;
                  else                  bad_fn = 1'b1;
               end
            endcase
         end
         7'h33: begin
            use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
            if (f7 == 7'h00) begin
               case (f3)
                  3'd0: dec_kind = 6'd28;
                  3'd1: dec_kind = 6'd30;
                  3'd2: dec_kind = 6'd31;
                  3'd3: dec_kind = 6'd32;
                  3'd4: dec_kind = 6'd33;
                  3'd5: dec_kind = 6'd34;
                  3'd6: dec_kind = 6'd36;
                  default: dec_kind = 6'd37;
               endcase
            end else if (f7 == 7'h20 && f3 == 3'd0) begin
               dec_kind = 6'd29;
            end else if (f7 == 7'h20 && f3 == 3'd5) begin
               dec_kind = 6'd35;
            end else begin
               bad_fn = 1'b1;
            end
         end
         7'h0F, 7'h73: bad_opc = !SYSTEM_AS_NOP;
         default: bad_opc = 1'b1;
      endcase
   end

   assign bad_reg = (use_rd && reg_oob(rd5)) || (use_rs1 && reg_oob(rs15)) ||
                    (use_rs2 && reg_oob(rs25));
   assign dec_cause = bad_opc ? 2'd1 : bad_fn ? 2'd2 : bad_reg ? 2'd3 : 2'd0;

   assign dec_op.kind = dec_kind;
   assign dec_op.imm  = dec_imm;
   assign dec_op.rd   = use_rd  ? rd5[REG_BITS-1:0]  : '0;
   assign dec_op.rs1  = use_rs1 ? rs15[REG_BITS-1:0] : '0;
   assign dec_op.rs2  = use_rs2 ? rs25[REG_BITS-1:0] : '0;
   assign dec_op.pc   = fetch_pc;

   logic main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
   op_t main_q, main_d, skid_q, skid_d;
   logic err_vld_q, err_vld_d;
   logic [1:0] err_cause_q, err_cause_d;
   logic [31:0] err_pc_q, err_pc_d, err_instr_q, err_instr_d;
   logic accept, push, out_xfer;

   assign fetch_ready = !err_vld_q && !skid_vld_q;
   assign accept      = fetch_valid && fetch_ready;
   assign push        = accept && (dec_cause == 2'd0);
   assign out_xfer    = main_vld_q && exec_ready;

   // Buffer next state: flush empties both slots, skid refills main on drain.
   always_comb begin
      main_vld_d = main_vld_q;
      skid_vld_d = skid_vld_q;
      main_d     = main_q;
      skid_d     = skid_q;
      if (flush) begin
         main_vld_d = 1'b0;
         skid_vld_d = 1'b0;
      end else if (out_xfer) begin
         if (skid_vld_q) begin
            main_d     = skid_q;
            skid_vld_d = 1'b0;
         end else if (push) begin
            main_d = dec_op;
         end else begin
            main_vld_d = 1'b0;
         end
      end else if (push) begin
         if (main_vld_q) begin
            skid_d     = dec_op;
            skid_vld_d = 1'b1;
         end else begin
            main_d     = dec_op;
            main_vld_d = 1'b1;
         end
      end
   end

   // Error next state: flush wins, then a new fault, then an explicit clear.
   always_comb begin
      err_vld_d   = err_vld_q;
      err_cause_d = err_cause_q;
      err_pc_d    = err_pc_q;
      err_instr_d = err_instr_q;
      if (flush) begin
         err_vld_d = 1'b0;
      end else if (accept && dec_cause != 2'd0) begin
         err_vld_d   = 1'b1;
         err_cause_d = dec_cause;
         err_pc_d    = fetch_pc;
         err_instr_d = fetch_instr;
      end else if (error_clear) begin
         err_vld_d = 1'b0;
      end
   end

   // State registers, cleared asynchronously.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         main_vld_q  <= 1'b0;
         skid_vld_q  <= 1'b0;
         main_q      <= '0;
         skid_q      <= '0;
         err_vld_q   <= 1'b0;
         err_cause_q <= 2'd0;
         err_pc_q    <= 32'd0;
         err_instr_q <= 32'd0;
      end else begin
         main_vld_q  <= main_vld_d;
         skid_vld_q  <= skid_vld_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         err_vld_q   <= err_vld_d;
         err_cause_q <= err_cause_d;
         err_pc_q    <= err_pc_d;
         err_instr_q <= err_instr_d;
      end
   end

   assign exec_valid  = main_vld_q;
   assign exec_kind   = main_q.kind;
   assign exec_imm    = main_q.imm;
   assign exec_rd     = main_q.rd;
   assign exec_rs1    = main_q.rs1;
   assign exec_rs2    = main_q.rs2;
   assign exec_pc     = main_q.pc;
   assign error_valid = err_vld_q;
   assign error_cause = err_cause_q;
   assign error_pc    = err_pc_q;
   assign error_instr = err_instr_q;
endmodule
